// File: rtl/vga_fb_pkg.sv
// =============================================================================
// vga_fb_pkg : shared types and constants for the frame-buffer scheduler
// Revision   : 1.0
// =============================================================================
`default_nettype none

package vga_fb_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_PIX_W    = 24;
  localparam int FRAME_PIX    = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_FLUSH = 2'd2;

  function automatic int frame_pix(input int h, input int v);
    return h * v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pix_fifo.sv
// =============================================================================
// vga_pix_fifo : synchronous pixel FIFO with flush and registered read data
// Revision     : 1.0
// =============================================================================
`default_nettype none

module vga_pix_fifo
  import vga_fb_pkg::*;
#(
  parameter int W     = DEF_PIX_W,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          do_pop;

  always_comb begin
    do_pop  = i_pop && (level_q != '0);
    rdata_d = rdata_q;
    // A pop against an empty FIFO presents black rather than stale data.
    if (i_pop) rdata_d = do_pop ? mem_q[rptr_q] : '0;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (i_push) wptr_d = wptr_q + 1'b1;
      if (do_pop) rptr_d = rptr_q + 1'b1;
      case ({i_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wptr_q] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) assert (level_q <= DEPTH_L);
  end

  assign o_rdata = rdata_q;
  assign o_level = level_q;
  assign o_empty = (level_q == '0);

endmodule

`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
// =============================================================================
// vga_fb_scheduler : single-port frame-buffer arbiter, display prefetch vs writer
// Revision         : 1.0
// =============================================================================
`default_nettype none

module vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_request,
  output logic [PIX_W-1:0]  o_color,
  output logic              o_underflow,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [PIX_W-1:0]  o_mem_wdata,
  input  logic [PIX_W-1:0]  i_mem_rdata
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = LVL_W + 3;
  localparam logic [ADDR_W:0]   FRAME_L = (ADDR_W+1)'(frame_pix(H_ACTIVE, V_ACTIVE));
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] LOW_C   = CRED_W'(LOW_WM);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              epoch_q, epoch_d;
  logic              rd_tag_q, rd_tag_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              underflow_q, underflow_d;

  logic [CRED_W-1:0] inflight, credit;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_empty, push, rd_legal, do_rd, do_wr;

  vga_pix_fifo #(.W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_frame_start),
    .i_push      (push),
    .i_push_data (i_mem_rdata),
    .i_pop       (i_request),
    .o_rdata     (o_color),
    .o_level     (fifo_level),
    .o_empty     (fifo_empty)
  );

  always_comb begin
    // Outstanding reads: the one on the SRAM pins plus every tracked return slot.
    inflight = CRED_W'(mem_en_q & ~mem_we_q);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CRED_W'(vld_q[i]);
    credit = CRED_W'(fifo_level) + inflight;

    rd_legal = (state_q == S_RUN) && !i_frame_start &&
               (credit < DEPTH_C) && (rd_addr_q < FRAME_L);
    do_rd    = rd_legal && ((credit < LOW_C) || !i_wr_valid);
    do_wr    = i_wr_valid && !do_rd;

    push = vld_q[RD_LAT-1] && (tag_q[RD_LAT-1] == epoch_q);

    vld_d[0] = mem_en_q & ~mem_we_q;
    tag_d[0] = rd_tag_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    mem_en_d    = do_rd || do_wr;
    mem_we_d    = do_wr;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_tag_d    = epoch_q;
    if (do_rd) begin
      mem_addr_d = rd_addr_q[ADDR_W-1:0];
    end else if (do_wr) begin
      mem_addr_d  = i_wr_addr;
      mem_wdata_d = i_wr_data;
    end

    rd_addr_d = rd_addr_q;
    if (i_frame_start)  rd_addr_d = '0;
    else if (do_rd)     rd_addr_d = rd_addr_q + 1'b1;

    // A repeated frame start inside the flush must not re-validate old reads.
    epoch_d = epoch_q;
    if (i_frame_start && (state_q != S_FLUSH)) epoch_d = ~epoch_q;

    underflow_d = underflow_q;
    if (i_frame_start)                 underflow_d = 1'b0;
    else if (i_request && fifo_empty)  underflow_d = 1'b1;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_frame_start) state_d = S_FLUSH;
      S_RUN:   if (i_frame_start) state_d = S_FLUSH;
      S_FLUSH: if (!i_frame_start && (inflight == '0)) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      epoch_q     <= 1'b0;
      rd_tag_q    <= 1'b0;
      vld_q       <= '0;
      tag_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      epoch_q     <= epoch_d;
      rd_tag_q    <= rd_tag_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      underflow_q <= underflow_d;
    end
  end

  // Ready marks the cycle the write is accepted; the access itself leaves registered.
  assign o_wr_ready  = do_wr && i_rst_n;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
// =============================================================================
// tb_vga_fb_scheduler : directed bench with an SRAM model returning data = addr
// Revision            : 1.0
// =============================================================================
`default_nettype none

module tb_vga_fb_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_frame_start, i_request, i_wr_valid;
  logic [18:0] i_wr_addr;
  logic [23:0] i_wr_data;
  logic [23:0] o_color;
  logic        o_underflow, o_wr_ready, o_mem_en, o_mem_we;
  logic [18:0] o_mem_addr;
  logic [23:0] o_mem_wdata;
  logic [23:0] i_mem_rdata;

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          mark;
  logic [18:0] last_rd = '1;
  logic [18:0] first_addr = '1;
  bit          capture_first = 1'b0;
  logic [23:0] pipe [2];

  always #5 i_clk = ~i_clk;

  vga_fb_scheduler #(
    .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(19), .PIX_W(24),
    .RD_LAT(2), .FIFO_DEPTH(16), .LOW_WM(6)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_request(i_request), .o_color(o_color), .o_underflow(o_underflow),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  // SRAM model: read data equals the address, valid two cycles after o_mem_en.
  assign i_mem_rdata = pipe[1];
  always @(posedge i_clk) begin
    pipe[1] <= pipe[0];
    pipe[0] <= {5'd0, o_mem_addr};
    if (o_mem_en === 1'b1 && o_mem_we === 1'b0) begin
      rd_cnt++;
      last_rd = o_mem_addr;
      if (capture_first) begin
        first_addr    = o_mem_addr;
        capture_first = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_frame_start = 1'b0; i_request = 1'b0;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    repeat (3) cyc();
    chk("rst_color", o_color, 0);
    chk("rst_underflow", o_underflow, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_mem_en", o_mem_en, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);

    // Pop before any frame start: black pixel and sticky underflow.
    i_rst_n = 1'b1;
    cyc();
    i_request = 1'b1;
    cyc();
    i_request = 1'b0;
    chk("idle_pop_color", o_color, 0);
    chk("idle_underflow", o_underflow, 1);
    repeat (5) cyc();
    chk("idle_underflow_held", o_underflow, 1);
    chk("idle_no_reads", rd_cnt, 0);

    // Frame start clears underflow; prefetch fills exactly 16 entries.
    i_frame_start = 1'b1;
    cyc();
    i_frame_start = 1'b0;
    chk("fs_clears_underflow", o_underflow, 0);
    repeat (30) cyc();
    chk("fill_reads", rd_cnt, 16);
    chk("fill_last_addr", last_rd, 15);
    chk("fill_no_en", o_mem_en, 0);

    // Writer wins while credit stays at or above the watermark.
    i_wr_valid = 1'b1; i_wr_addr = 19'h12345; i_wr_data = 24'hABCDEF;
    i_request = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("wr_ready_hi", o_wr_ready, 1);
      cyc();
      chk("pop_color_a", o_color, k);
      chk("wr_we", o_mem_we, 1);
    end
    i_request = 1'b0;
    #1;
    chk("wr_ready_hold", o_wr_ready, 1);
    cyc();
    chk("wr_en", o_mem_en, 1);
    chk("wr_addr", o_mem_addr, 19'h12345);
    chk("wr_wdata", o_mem_wdata, 24'hABCDEF);
    i_wr_addr = 19'h00777; i_wr_data = 24'h135790;
    i_request = 1'b1;
    for (int k = 6; k < 11; k++) begin
      cyc();
      chk("pop_color_b", o_color, k);
    end
    i_request = 1'b0;
    // Level 5 is below the watermark: the read takes the slot.
    #1;
    chk("urgent_ready_lo", o_wr_ready, 0);
    cyc();
    chk("urgent_en", o_mem_en, 1);
    chk("urgent_we", o_mem_we, 0);
    chk("urgent_addr", o_mem_addr, 16);
    i_wr_valid = 1'b0;

    // Frame start with reads in flight: stale returns must be dropped.
    i_request = 1'b1;
    for (int k = 11; k < 18; k++) begin
      cyc();
      chk("pop_color_c", o_color, k);
    end
    i_request = 1'b0;
    i_frame_start = 1'b1;
    cyc();
    i_frame_start = 1'b0;
    capture_first = 1'b1;
    chk("flush_no_read0", o_mem_en, 0);
    cyc();
    chk("flush_no_read1", o_mem_en, 0);
    repeat (30) cyc();
    chk("flush_first_addr", first_addr, 0);

    // Whole frame of 32 pixels after the flush.
    i_request = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cyc();
      chk("frame_color", o_color, k);
    end
    i_request = 1'b0;
    chk("frame_last_read", last_rd, 31);
    chk("frame_no_underflow", o_underflow, 0);
    mark = rd_cnt;
    repeat (20) cyc();
    chk("frame_done_no_reads", rd_cnt, mark);

    first_addr = '1;
    i_frame_start = 1'b1;
    cyc();
    i_frame_start = 1'b0;
    capture_first = 1'b1;
    repeat (10) cyc();
    chk("restart_addr", first_addr, 0);
    chk("color_hold", o_color, 31);

    // Reset mid-frame with a pending write, then serve it in idle.
    i_wr_valid = 1'b1; i_wr_addr = 19'h40001; i_wr_data = 24'h5A5A5A;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", o_wr_ready, 0);
    cyc();
    chk("rst_mid_color", o_color, 0);
    chk("rst_mid_en", o_mem_en, 0);
    chk("rst_mid_addr", o_mem_addr, 0);
    chk("rst_mid_wdata", o_mem_wdata, 0);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_ready", o_wr_ready, 1);
    cyc();
    chk("post_rst_en", o_mem_en, 1);
    chk("post_rst_we", o_mem_we, 1);
    chk("post_rst_addr", o_mem_addr, 19'h40001);
    chk("post_rst_wdata", o_mem_wdata, 24'h5A5A5A);
    i_wr_valid = 1'b0;
    mark = rd_cnt;
    repeat (10) cyc();
    chk("post_rst_no_reads", rd_cnt, mark);
    i_request = 1'b1;
    cyc();
    i_request = 1'b0;
    chk("post_rst_pop_color", o_color, 0);
    chk("post_rst_underflow", o_underflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
